// File: rtl/ram_fill_check_master.sv
// Avalon-MM memory self-test master: fills a word range with seed+i,
// optionally reads it back and counts mismatches. One transfer in flight.
module ram_fill_check_master #(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata
);

    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [LW-1:0] LAT = LW'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, FIN} state_t;

    state_t            state_q;
    logic [ADDR_W:0]   idx_q, cnt_q;
    logic [ADDR_W-1:0] base_q, addr_q, first_q;
    logic [31:0]       seed_q, wdata_q;
    logic              verify_q, abort_q;
    logic [LW-1:0]     lat_q;
    logic              busy_q, done_q, pass_q;
    logic              cs_q, rd_q, wr_q;
    logic [15:0]       err_q;

    logic [ADDR_W:0]   idx_d;
    logic [ADDR_W-1:0] addr_d, cur_addr;
    logic [31:0]       wdata_d, expect_w;
    logic [15:0]       err_d;
    logic              last, stop, miss;

    always_comb begin
        idx_d    = idx_q + 1'b1;
        last     = (idx_d == cnt_q);
        addr_d   = base_q + idx_d[ADDR_W-1:0];
        cur_addr = base_q + idx_q[ADDR_W-1:0];
        wdata_d  = seed_q + 32'(idx_d);
        expect_w = seed_q + 32'(idx_q);
        miss     = (avm_readdata != expect_w);
        stop     = abort | abort_q;
        err_d    = err_q;
        if (miss && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            first_q  <= '0;
            seed_q   <= '0;
            wdata_q  <= '0;
            verify_q <= 1'b0;
            abort_q  <= 1'b0;
            lat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    base_q   <= base_addr;
                    cnt_q    <= word_count;
                    seed_q   <= seed;
                    verify_q <= mode[0];
                    idx_q    <= '0;
                    abort_q  <= 1'b0;
                    err_q    <= '0;
                    first_q  <= '0;
                    pass_q   <= 1'b0;
                    if (word_count == '0) begin
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= base_addr;
                        wdata_q <= seed;
                        if (mode == 2'd2) begin
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end else begin
                            wr_q    <= 1'b1;
                            state_q <= WR;
                        end
                    end
                end
                WR: begin
                    if (abort) abort_q <= 1'b1;
                    if (!avm_waitrequest) begin
                        if (last && verify_q && !stop) begin
                            idx_q   <= '0;
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                            addr_q  <= base_q;
                            state_q <= RD;
                        end else if (last || stop) begin
                            cs_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !stop && err_q == '0;
                            state_q <= FIN;
                        end else begin
                            idx_q   <= idx_d;
                            addr_q  <= addr_d;
                            wdata_q <= wdata_d;
                        end
                    end
                end
                RD: begin
                    if (abort) abort_q <= 1'b1;
                    if (!avm_waitrequest) begin
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        lat_q   <= LW'(1);
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (abort) abort_q <= 1'b1;
                    if (lat_q == LAT) begin
                        err_q <= err_d;
                        if (miss && err_q == '0) first_q <= cur_addr;
                        if (last || stop) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !stop && err_d == '0;
                            state_q <= FIN;
                        end else begin
                            idx_q   <= idx_d;
                            addr_q  <= addr_d;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_byteenable = cs_q ? 4'hF : 4'h0;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_ram_fill_check_master.sv
// Bench for ram_fill_check_master: vector table plus directed
// sequences against a latency-1 Avalon RAM model with stall/corrupt hooks.
module tb_ram_fill_check_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [13:0] base = '0;
    logic [14:0] wc = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [13:0] first_err_addr, avm_address;
    logic        avm_chipselect, avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata = '0;

    always #5 clk = ~clk;

    ram_fill_check_master dut (
        .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .mode(mode), .base_addr(base), .word_count(wc), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata));

    logic [31:0]  mem [0:16383];
    byte unsigned hits [0:16383];
    logic [13:0]  wa_log [0:31];
    logic [31:0]  wd_log [0:31];
    int           wc_log [0:31];
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, wreq_cyc = 0, rreq_cyc = 0;
    int hold_cnt = 0, stall_used = 0, stall_cfg = 0;
    logic [13:0] stall_addr = '0, bad_addr = '0;
    bit stall_rd = 0, bad_on = 0, bad_all = 0;
    logic bad;

    assign avm_waitrequest = avm_chipselect && (avm_address == stall_addr)
        && (stall_rd ? avm_read : avm_write) && (stall_used < stall_cfg);
    assign bad = bad_all || (bad_on && avm_address == bad_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy) begin
            wr_cnt <= 0; rd_cnt <= 0; wreq_cyc <= 0; rreq_cyc <= 0;
            hold_cnt <= 0; stall_used <= 0;
            for (int i = 0; i < 16384; i++) hits[i] <= 8'd0;
        end else begin
            if (avm_chipselect && avm_write && !avm_waitrequest) begin
                mem[avm_address] <= avm_writedata;
                hits[avm_address] <= hits[avm_address] + 8'd1;
                if (wr_cnt < 32) begin
                    wa_log[wr_cnt] <= avm_address;
                    wd_log[wr_cnt] <= avm_writedata;
                    wc_log[wr_cnt] <= cyc;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (avm_chipselect && avm_read && !avm_waitrequest) begin
                avm_readdata <= mem[avm_address] ^ {31'b0, bad};
                rd_cnt <= rd_cnt + 1;
            end
            if (avm_chipselect && avm_write) wreq_cyc <= wreq_cyc + 1;
            if (avm_chipselect && avm_read) rreq_cyc <= rreq_cyc + 1;
            if (avm_chipselect && avm_write && avm_address == 14'd1
                && avm_writedata == 32'h1001) hold_cnt <= hold_cnt + 1;
            if (avm_waitrequest) stall_used <= stall_used + 1;
        end
    end

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic go(input logic [1:0] m, input logic [13:0] b,
                      input logic [14:0] c, input logic [31:0] s);
        @(negedge clk);
        mode = m; base = b; wc = c; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        bit got = 0;
        n = 0;
        for (int k = 0; k < limit; k++) begin
            if (done) begin got = 1; n = k; break; end
            @(negedge clk);
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_req(input bit rd, input logic [13:0] a,
                            input bit need_stall);
        bit got = 0;
        for (int k = 0; k < 50; k++) begin
            if ((rd ? avm_read : avm_write) && avm_address == a
                && (!need_stall || avm_waitrequest)) begin
                got = 1; break;
            end
            @(negedge clk);
        end
        if (!got) chk("req_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] outs_ctrl();
        return 64'({busy, done, pass, err_count, first_err_addr, avm_address,
                    avm_chipselect, avm_read, avm_write, avm_byteenable});
    endfunction

    typedef struct {
        logic [1:0] m; logic [13:0] b; logic [14:0] c; logic [31:0] s;
        bit bon; bit ball; logic [13:0] ba;
        int ncyc; bit ps; logic [15:0] err; logic [13:0] first;
        int wr; int rd;
    } vec_t;

    localparam logic [31:0] S = 32'hABCD_0000;

    initial begin
        vec_t v [8];
        int n, lm, hb;
        logic [13:0] ea;
        v[0] = '{2'd1, 14'h0,    15'd4, 32'h1000,     0, 0, 14'h0,   12, 1, 16'd0, 14'h0,   4, 4};
        v[1] = '{2'd0, 14'h100,  15'd5, S,            1, 0, 14'h102,  5, 1, 16'd0, 14'h0,   5, 0};
        v[2] = '{2'd2, 14'h100,  15'd5, S,            1, 0, 14'h102, 10, 0, 16'd1, 14'h102, 0, 5};
        v[3] = '{2'd1, 14'h3FFE, 15'd4, 32'hFFFFFFFE, 0, 0, 14'h0,   12, 1, 16'd0, 14'h0,   4, 4};
        v[4] = '{2'd3, 14'h20,   15'd3, 32'd5,        0, 0, 14'h0,    9, 1, 16'd0, 14'h0,   3, 3};
        v[5] = '{2'd1, 14'h40,   15'd3, 32'h77,       1, 0, 14'h41,   9, 0, 16'd1, 14'h41,  3, 3};
        v[6] = '{2'd2, 14'h100,  15'd3, S,            0, 1, 14'h0,    6, 0, 16'd3, 14'h100, 0, 3};
        v[7] = '{2'd1, 14'h0,    15'd0, 32'd0,        0, 0, 14'h0,    0, 1, 16'd0, 14'h0,   0, 0};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", outs_ctrl(), 64'd0);
        chk("reset_wdata", 64'(avm_writedata), 64'd0);
        rst_n = 1'b1;

        for (int j = 0; j < 8; j++) begin
            bad_on = v[j].bon; bad_all = v[j].ball; bad_addr = v[j].ba;
            go(v[j].m, v[j].b, v[j].c, v[j].s);
            wait_done(200, n);
            chk($sformatf("v%0d_cycles", j), 64'(n), 64'(v[j].ncyc));
            chk($sformatf("v%0d_pass", j), 64'(pass), 64'(v[j].ps));
            chk($sformatf("v%0d_err", j), 64'(err_count), 64'(v[j].err));
            chk($sformatf("v%0d_first", j), 64'(first_err_addr), 64'(v[j].first));
            chk($sformatf("v%0d_writes", j), 64'(wr_cnt), 64'(v[j].wr));
            chk($sformatf("v%0d_reads", j), 64'(rd_cnt), 64'(v[j].rd));
            lm = 0;
            for (int i = 0; i < wr_cnt && i < 32; i++) begin
                ea = v[j].b + 14'(i);
                if (wa_log[i] !== ea || wd_log[i] !== v[j].s + 32'(i)) lm++;
            end
            chk($sformatf("v%0d_wlog", j), 64'(lm), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_after", j), 64'({done, busy}), 64'd0);
            if (j == 0)
                chk("v0_back2back", 64'(wc_log[3] - wc_log[0]), 64'd3);
            if (j == 3) begin
                chk("wrap_a1", 64'(wa_log[1]), 64'h3FFF);
                chk("wrap_a2", 64'(wa_log[2]), 64'h0000);
                chk("wrap_d2", 64'(wd_log[2]), 64'h0);
            end
        end
        bad_on = 0; bad_all = 0;

        // write stalled 3 cycles on the second word
        stall_cfg = 3; stall_addr = 14'd1; stall_rd = 0;
        go(2'd1, 14'h0, 15'd4, 32'h1000);
        wait_done(200, n);
        chk("stall_hold", 64'(hold_cnt), 64'd4);
        chk("stall_wphase", 64'(wreq_cyc), 64'd7);
        chk("stall_writes", 64'(wr_cnt), 64'd4);
        chk("stall_cycles", 64'(n), 64'd15);
        chk("stall_pass", 64'(pass), 64'd1);

        // abort while a read is stalled, plus a start pulse while busy
        stall_cfg = 3; stall_addr = 14'h101; stall_rd = 1;
        bad_on = 1; bad_addr = 14'h101;
        go(2'd2, 14'h100, 15'd4, S);
        wait_req(1'b1, 14'h101, 1'b1);
        abort = 1'b1; start = 1'b1; mode = 2'd0; base = 14'h200;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, n);
        abort = 1'b0;
        chk("abort_pass", 64'(pass), 64'd0);
        chk("abort_reads", 64'(rd_cnt), 64'd2);
        chk("abort_rreq", 64'(rreq_cyc), 64'd5);
        chk("abort_err", 64'(err_count), 64'd1);
        chk("abort_first", 64'(first_err_addr), 64'h101);
        repeat (3) @(negedge clk);
        chk("busy_start_ignored", 64'({busy, 32'(wr_cnt)}), 64'd0);
        stall_cfg = 0; bad_on = 0;

        // abort in idle
        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_abort", 64'({busy, done, avm_chipselect}), 64'd0);
        abort = 1'b0;

        // abort coinciding with the last write accept
        go(2'd0, 14'h500, 15'd2, 32'd9);
        wait_req(1'b0, 14'h501, 1'b0);
        abort = 1'b1;
        wait_done(50, n);
        abort = 1'b0;
        chk("lastabort_pass", 64'(pass), 64'd0);
        chk("lastabort_writes", 64'(wr_cnt), 64'd2);

        // whole address space, mode 0
        go(2'd0, 14'h1234, 15'd16384, 32'd0);
        wait_done(20000, n);
        hb = 0;
        for (int i = 0; i < 16384; i++) if (hits[i] != 8'd1) hb++;
        chk("full_writes", 64'(wr_cnt), 64'd16384);
        chk("full_hits", 64'(hb), 64'd0);
        chk("full_cycles", 64'(n), 64'd16384);
        chk("full_pass", 64'(pass), 64'd1);

        // reset in the middle of a fill
        go(2'd0, 14'h600, 15'd10, 32'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", outs_ctrl(), 64'd0);
        chk("midrst_wdata", 64'(avm_writedata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        go(2'd1, 14'h600, 15'd2, 32'h42);
        wait_done(100, n);
        chk("postrst_pass", 64'(pass), 64'd1);
        chk("postrst_cycles", 64'(n), 64'd6);
        chk("postrst_writes", 64'({32'(wr_cnt), 32'(rd_cnt)}), {32'd2, 32'd2});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
